// File: rtl/c_range_counter_bank_pkg.sv
// rtl/c_range_counter_bank_pkg.sv - shared mode constants and parameter checks for the range counter bank
package c_range_counter_bank_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit range_ok(input int channels, input int w, input int lo, input int hi,
                                  input int rst_val, input int md);
    return (channels >= 1) && (w >= 1) && (w <= 30) && (lo >= 0) && (lo <= hi) &&
           (hi < (1 << w)) && (rst_val >= lo) && (rst_val <= hi) &&
           ((md == MODE_WRAP) || (md == MODE_SATURATE));
  endfunction

endpackage

// File: rtl/c_range_counter_bank_step.sv
// rtl/c_range_counter_bank_step.sv - combinational next-value and boundary flag for one range counter
module c_range_step
  import c_range_counter_bank_pkg::*;
#(
  parameter int width     = 4,
  parameter int min_value = 4,
  parameter int max_value = 7
) (
  input  logic [width-1:0] value,
  input  logic             inc,
  input  logic             dec,
  input  logic             mode,
  output logic [width-1:0] next_value,
  output logic             boundary
);

  localparam logic [width-1:0] MIN_V   = width'(min_value);
  localparam logic [width-1:0] MAX_V   = width'(max_value);
  localparam logic [width:0]   MIN_EXT = (width + 1)'(min_value);
  localparam logic [width:0]   MAX_EXT = (width + 1)'(max_value);
  localparam logic             SAT_BIT = 1'(MODE_SATURATE);

  logic [width:0] value_ext;
  logic [width:0] inc_ext;

  // The extra bit keeps max_value == 2^width-1 from aliasing back to zero.
  assign value_ext = {1'b0, value};
  assign inc_ext   = value_ext + (width + 1)'(1);

  always_comb begin
    next_value = value;
    boundary   = 1'b0;
    if (inc && !dec) begin
      if (inc_ext > MAX_EXT) begin
        boundary   = 1'b1;
        next_value = (mode == SAT_BIT) ? value : MIN_V;
      end else begin
        next_value = inc_ext[width-1:0];
      end
    end else if (dec && !inc) begin
      if (value_ext <= MIN_EXT) begin
        boundary   = 1'b1;
        next_value = (mode == SAT_BIT) ? value : MAX_V;
      end else begin
        next_value = value - width'(1);
      end
    end
  end

endmodule

// File: rtl/c_range_counter_bank.sv
// rtl/c_range_counter_bank.sv - bank of independent registered counters confined to [min_value, max_value]
module c_range_counter_bank
  import c_range_counter_bank_pkg::*;
#(
  parameter int num_channels = 4,
  parameter int width        = 4,
  parameter int min_value    = 4,
  parameter int max_value    = 7,
  parameter int reset_value  = min_value,
  parameter int mode         = MODE_WRAP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [num_channels-1:0]       clear,
  input  logic [num_channels-1:0]       load,
  input  logic [num_channels*width-1:0] load_data,
  input  logic [num_channels-1:0]       inc,
  input  logic [num_channels-1:0]       dec,
  output logic [num_channels*width-1:0] value,
  output logic [num_channels-1:0]       wrapped,
  output logic [num_channels-1:0]       at_max,
  output logic [num_channels-1:0]       at_min
);

  localparam logic [width-1:0] MIN_V    = width'(min_value);
  localparam logic [width-1:0] MAX_V    = width'(max_value);
  localparam logic [width-1:0] RESET_V  = width'(reset_value);
  localparam logic [width:0]   MIN_EXT  = (width + 1)'(min_value);
  localparam logic [width:0]   MAX_EXT  = (width + 1)'(max_value);
  localparam logic             SAT_MODE = (mode == MODE_SATURATE);

  if (!range_ok(num_channels, width, min_value, max_value, reset_value, mode)) begin : g_param_check
    $fatal(1, "c_range_counter_bank: illegal range parameters");
  end

  for (genvar c = 0; c < num_channels; c++) begin : g_ch
    logic [width-1:0] value_q, value_d;
    logic             wrapped_q, wrapped_d;
    logic [width-1:0] step_value;
    logic             step_boundary;
    logic [width:0]   load_ext;
    logic [width-1:0] load_clamped;

    c_range_step #(
      .width     (width),
      .min_value (min_value),
      .max_value (max_value)
    ) u_step (
      .value      (value_q),
      .inc        (inc[c]),
      .dec        (dec[c]),
      .mode       (SAT_MODE),
      .next_value (step_value),
      .boundary   (step_boundary)
    );

    // Below-min test written as x+1 <= min so a zero minimum stays a live comparison.
    assign load_ext     = {1'b0, load_data[c*width +: width]};
    assign load_clamped = (load_ext > MAX_EXT)                      ? MAX_V :
                          ((load_ext + (width + 1)'(1)) <= MIN_EXT) ? MIN_V :
                                                                      load_ext[width-1:0];

    always_comb begin
      value_d   = value_q;
      wrapped_d = 1'b0;
      if (clear[c]) begin
        value_d = MIN_V;
      end else if (load[c]) begin
        value_d = load_clamped;
      end else begin
        value_d   = step_value;
        wrapped_d = step_boundary;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        value_q   <= RESET_V;
        wrapped_q <= 1'b0;
      end else begin
        value_q   <= value_d;
        wrapped_q <= wrapped_d;
      end
    end

    assign value[c*width +: width] = value_q;
    assign wrapped[c]              = wrapped_q;
    assign at_max[c]               = (value_q == MAX_V);
    assign at_min[c]               = (value_q == MIN_V);
  end

endmodule

// File: tb/tb_c_range_counter_bank.sv
// tb/tb_c_range_counter_bank.sv - scoreboard bench for the range counter bank across modes and ranges
module tb_c_range_counter_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          dut;
    logic [15:0] val;
    logic [3:0]  wr;
  } exp_t;
  exp_t exp_q[$];

  logic [3:0]  clr0, ld0, inc0, dec0, wr0, amax0, amin0;
  logic [15:0] ldd0, val0;
  logic [3:0]  clr1, ld1, inc1, dec1, wr1, amax1, amin1;
  logic [15:0] ldd1, val1;
  logic        clr2, ld2, inc2, dec2, wr2, amax2, amin2;
  logic [1:0]  ldd2, val2;
  logic        clr3, ld3, inc3, dec3, wr3, amax3, amin3;
  logic [2:0]  ldd3, val3;

  c_range_counter_bank #(.mode(0)) dut0 (
    .clk(clk), .reset(rst_n), .clear(clr0), .load(ld0), .load_data(ldd0), .inc(inc0), .dec(dec0),
    .value(val0), .wrapped(wr0), .at_max(amax0), .at_min(amin0));

  c_range_counter_bank #(.mode(1)) dut1 (
    .clk(clk), .reset(rst_n), .clear(clr1), .load(ld1), .load_data(ldd1), .inc(inc1), .dec(dec1),
    .value(val1), .wrapped(wr1), .at_max(amax1), .at_min(amin1));

  c_range_counter_bank #(.num_channels(1), .width(2), .min_value(3), .max_value(3), .reset_value(3),
                         .mode(0)) dut2 (
    .clk(clk), .reset(rst_n), .clear(clr2), .load(ld2), .load_data(ldd2), .inc(inc2), .dec(dec2),
    .value(val2), .wrapped(wr2), .at_max(amax2), .at_min(amin2));

  c_range_counter_bank #(.num_channels(1), .width(3), .min_value(0), .max_value(7), .reset_value(0),
                         .mode(0)) dut3 (
    .clk(clk), .reset(rst_n), .clear(clr3), .load(ld3), .load_data(ldd3), .inc(inc3), .dec(dec3),
    .value(val3), .wrapped(wr3), .at_max(amax3), .at_min(amin3));

  function automatic logic [15:0] obs_val(input int d);
    case (d)
      0:       return val0;
      1:       return val1;
      2:       return {14'd0, val2};
      default: return {13'd0, val3};
    endcase
  endfunction

  function automatic logic [3:0] obs_wr(input int d);
    case (d)
      0:       return wr0;
      1:       return wr1;
      2:       return {3'd0, wr2};
      default: return {3'd0, wr3};
    endcase
  endfunction

  task automatic drive_idle();
    clr0 = '0; ld0 = '0; ldd0 = '0; inc0 = '0; dec0 = '0;
    clr1 = '0; ld1 = '0; ldd1 = '0; inc1 = '0; dec1 = '0;
    clr2 = '0; ld2 = '0; ldd2 = '0; inc2 = '0; dec2 = '0;
    clr3 = '0; ld3 = '0; ldd3 = '0; inc3 = '0; dec3 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    inc0 = 4'hF;
    inc1 = 4'hF;
    rst_n = 1'b0;
    #3;
    checks++;
    if (val0 !== 16'h4444) begin
      errors++; $display("FAIL reset_async_value got=%h want=%h", val0, 16'h4444);
    end
    repeat (2) tick();
    checks++;
    if (val0 !== 16'h4444 || val1 !== 16'h4444) begin
      errors++; $display("FAIL reset_hold_value got=%h/%h want=4444", val0, val1);
    end
    checks++;
    if (wr0 !== 4'h0) begin
      errors++; $display("FAIL reset_wrapped got=%h want=0", wr0);
    end
    checks++;
    if (amin0 !== 4'hF || amax0 !== 4'h0) begin
      errors++; $display("FAIL reset_flags at_min=%h at_max=%h want F/0", amin0, amax0);
    end
    checks++;
    if (val2 !== 2'd3 || val3 !== 3'd0) begin
      errors++; $display("FAIL reset_sweep got=%0d/%0d want 3/0", val2, val3);
    end
    #2;
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_inc_wrap();
    logic [15:0] exp_v [5];
    exp_t e;
    exp_v = '{16'h4445, 16'h4446, 16'h4447, 16'h4444, 16'h4444};
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      if (i < 4) inc0 = 4'b0001;
      e.tag = $sformatf("inc_wrap_%0d", i);
      e.dut = 0;
      e.val = exp_v[i];
      e.wr  = (i == 3) ? 4'b0001 : 4'b0000;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_val(e.dut) !== e.val) begin
        errors++; $display("FAIL %s value got=%h want=%h", e.tag, obs_val(e.dut), e.val);
      end
      checks++;
      if (obs_wr(e.dut) !== e.wr) begin
        errors++; $display("FAIL %s wrapped got=%h want=%h", e.tag, obs_wr(e.dut), e.wr);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      e.dut = 1;
      e.tag = $sformatf("saturate_%0d", i);
      if (i == 0) begin
        ld1 = 4'b0010; ldd1 = 16'h0070; e.val = 16'h4474; e.wr = 4'b0000;
      end else if (i < 4) begin
        inc1 = 4'b0010; e.val = 16'h4474; e.wr = 4'b0010;
      end else begin
        dec1 = 4'b0010; e.val = 16'h4464; e.wr = 4'b0000;
      end
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_val(e.dut) !== e.val) begin
        errors++; $display("FAIL %s value got=%h want=%h", e.tag, obs_val(e.dut), e.val);
      end
      checks++;
      if (obs_wr(e.dut) !== e.wr) begin
        errors++; $display("FAIL %s wrapped got=%h want=%h", e.tag, obs_wr(e.dut), e.wr);
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (amax1 !== 4'b0010) begin
          errors++; $display("FAIL %s at_max got=%h want=2", e.tag, amax1);
        end
      end
    end
  endtask

  task automatic test_wrap_dec();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive_idle();
      e.dut = 0;
      e.tag = $sformatf("wrap_dec_%0d", i);
      e.val = 16'h4744;
      e.wr  = (i == 0) ? 4'b0100 : 4'b0000;
      if (i == 0) dec0 = 4'b0100;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_val(e.dut) !== e.val) begin
        errors++; $display("FAIL %s value got=%h want=%h", e.tag, obs_val(e.dut), e.val);
      end
      checks++;
      if (obs_wr(e.dut) !== e.wr) begin
        errors++; $display("FAIL %s wrapped got=%h want=%h", e.tag, obs_wr(e.dut), e.wr);
      end
    end
    checks++;
    if (amax0 !== 4'b0100 || amin0 !== 4'b1011) begin
      errors++; $display("FAIL wrap_dec_flags at_max=%h at_min=%h want 4/B", amax0, amin0);
    end
  endtask

  task automatic test_load();
    logic [15:0] ldv   [4];
    logic [15:0] exp_v [4];
    exp_t e;
    ldv   = '{16'h2000, 16'hF000, 16'h6000, 16'h5000};
    exp_v = '{16'h4744, 16'h7744, 16'h6744, 16'h4744};
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      ld0  = 4'b1000;
      ldd0 = ldv[i];
      if (i == 3) begin
        clr0 = 4'b1000; inc0 = 4'b1000;
      end
      e.tag = $sformatf("load_%0d", i);
      e.dut = 0;
      e.val = exp_v[i];
      e.wr  = 4'b0000;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_val(e.dut) !== e.val) begin
        errors++; $display("FAIL %s value got=%h want=%h", e.tag, obs_val(e.dut), e.val);
      end
      checks++;
      if (obs_wr(e.dut) !== e.wr) begin
        errors++; $display("FAIL %s wrapped got=%h want=%h", e.tag, obs_wr(e.dut), e.wr);
      end
    end
  endtask

  task automatic test_inc_dec_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      e.dut = 0;
      e.tag = $sformatf("inc_dec_%0d", i);
      case (i)
        0: begin ld0 = 4'b0001; ldd0 = 16'h0007; e.val = 16'h4747; e.wr = 4'b0000; end
        1: begin inc0 = 4'b0001; dec0 = 4'b0001; e.val = 16'h4747; e.wr = 4'b0000; end
        default: begin inc0 = 4'b0001; e.val = 16'h4744; e.wr = 4'b0001; end
      endcase
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_val(e.dut) !== e.val) begin
        errors++; $display("FAIL %s value got=%h want=%h", e.tag, obs_val(e.dut), e.val);
      end
      checks++;
      if (obs_wr(e.dut) !== e.wr) begin
        errors++; $display("FAIL %s wrapped got=%h want=%h", e.tag, obs_wr(e.dut), e.wr);
      end
    end
    drive_idle();
    inc0 = 4'b0100;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (val0 !== 16'h4444 || val1 !== 16'h4444) begin
      errors++; $display("FAIL midreset_value got=%h/%h want=4444", val0, val1);
    end
    checks++;
    if (wr0 !== 4'h0) begin
      errors++; $display("FAIL midreset_wrapped got=%h want=0", wr0);
    end
    tick();
    checks++;
    if (val0 !== 16'h4444) begin
      errors++; $display("FAIL midreset_discard got=%h want=4444", val0);
    end
    #2;
    drive_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      case (i)
        0: begin inc2 = 1'b1; ld3 = 1'b1; ldd3 = 3'd7; end
        1: begin dec2 = 1'b1; inc3 = 1'b1; end
        default: dec3 = 1'b1;
      endcase
      e.tag = $sformatf("sweep_eq_%0d", i);
      e.dut = 2;
      e.val = 16'd3;
      e.wr  = (i < 2) ? 4'd1 : 4'd0;
      exp_q.push_back(e);
      e.tag = $sformatf("sweep_full_%0d", i);
      e.dut = 3;
      e.val = (i == 1) ? 16'd0 : 16'd7;
      e.wr  = (i == 0) ? 4'd0 : 4'd1;
      exp_q.push_back(e);
      tick();
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_val(e.dut) !== e.val) begin
          errors++; $display("FAIL %s value got=%h want=%h", e.tag, obs_val(e.dut), e.val);
        end
        checks++;
        if (obs_wr(e.dut) !== e.wr) begin
          errors++; $display("FAIL %s wrapped got=%h want=%h", e.tag, obs_wr(e.dut), e.wr);
        end
      end
    end
    checks++;
    if (amax2 !== 1'b1 || amin2 !== 1'b1) begin
      errors++; $display("FAIL sweep_eq_flags at_max=%b at_min=%b want 1/1", amax2, amin2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst_n = 1'b1;
    #2;
    test_reset();
    test_inc_wrap();
    test_saturate();
    test_wrap_dec();
    test_load();
    test_inc_dec_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
